// File: rtl/kernel_mac_engine.sv
// kernel_mac_engine: streams KERNEL_LEN signed activations, multiplies each by the
// kernel weight read at o_k_addr, and returns the signed dot product on a
// valid/ready result port.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_start, i_kernel_valid   start pulse, honoured in IDLE only when kernel loaded
//   i_abort                   synchronous abort back to IDLE
//   o_k_addr, i_k_data        kernel read address / weight (combinational read)
//   i_act_valid/data, o_act_ready   activation stream
//   o_res_valid/data, i_res_ready   result handshake
//   o_busy, o_done            not-idle flag, result-handshake pulse
module kernel_mac_engine #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned KERNEL_LEN = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned ACC_W      = 22
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_kernel_valid,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_k_addr,
  input  logic [DATA_W-1:0] i_k_data,
  input  logic              i_act_valid,
  input  logic [DATA_W-1:0] i_act_data,
  output logic              o_act_ready,
  output logic              o_res_valid,
  output logic [ACC_W-1:0]  o_res_data,
  input  logic              i_res_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_OUT} state_t;

  state_t                    state, state_n;
  logic [ADDR_W-1:0]         idx, idx_n;
  logic signed [ACC_W-1:0]   acc, acc_n;
  logic [ACC_W-1:0]          res, res_n;
  logic                      act_ready_q, res_valid_q, busy_q;
  logic signed [DATA_W-1:0]  act_s, k_s;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   sum;
  logic                      beat, last;
  logic                      done_c;

  // Signed multiply-accumulate of the current beat
  always_comb begin
    act_s = $signed(i_act_data);
    k_s   = $signed(i_k_data);
    prod  = act_s * k_s;
    sum   = acc + ACC_W'(prod);
    beat  = (state == ST_RUN) && i_act_valid;
    last  = (idx == ADDR_W'(KERNEL_LEN - 1));
  end

  // Next-state and datapath updates; abort overrides everything
  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc_n   = acc;
    res_n   = res;
    done_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start && i_kernel_valid) begin
          state_n = ST_RUN;
          acc_n   = '0;
          idx_n   = '0;
        end
      end
      ST_RUN: begin
        if (beat) begin
          acc_n = sum;
          if (last) begin
            res_n   = sum;
            idx_n   = '0;
            state_n = ST_OUT;
          end else begin
            idx_n = idx + ADDR_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (i_res_ready) begin
          done_c  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (i_abort) begin
      state_n = ST_IDLE;
      acc_n   = '0;
      idx_n   = '0;
      done_c  = 1'b0;
    end
  end

  // State, datapath and registered status flags (decoded from next state)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      acc         <= '0;
      res         <= '0;
      act_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      acc         <= acc_n;
      res         <= res_n;
      act_ready_q <= (state_n == ST_RUN);
      res_valid_q <= (state_n == ST_OUT);
      busy_q      <= (state_n != ST_IDLE);
    end
  end

  assign o_k_addr    = idx;
  assign o_act_ready = act_ready_q;
  assign o_res_valid = res_valid_q;
  assign o_res_data  = res;
  assign o_busy      = busy_q;
  // Handshake-cycle pulse, so it follows i_res_ready within the cycle
  assign o_done      = done_c;

endmodule

// File: tb/tb_kernel_mac_engine.sv
module tb_kernel_mac_engine;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned KLEN   = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned ACC_W  = 22;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, kernel_valid, abort;
  logic [ADDR_W-1:0] k_addr;
  logic [DATA_W-1:0] k_data;
  logic              act_valid;
  logic [DATA_W-1:0] act_data;
  logic              act_ready;
  logic              res_valid;
  logic [ACC_W-1:0]  res_data;
  logic              res_ready;
  logic              busy, done;

  logic signed [DATA_W-1:0] kmem [KLEN];
  logic signed [DATA_W-1:0] acts [KLEN];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  kernel_mac_engine #(.DATA_W(DATA_W), .KERNEL_LEN(KLEN), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_kernel_valid(kernel_valid),
    .i_abort(abort), .o_k_addr(k_addr), .i_k_data(k_data), .i_act_valid(act_valid),
    .i_act_data(act_data), .o_act_ready(act_ready), .o_res_valid(res_valid),
    .o_res_data(res_data), .i_res_ready(res_ready), .o_busy(busy), .o_done(done)
  );

  // Kernel register model: combinational read
  assign k_data = kmem[k_addr];

  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference dot product straight from the arrays
  function automatic longint ref_dot();
    longint s = 0;
    for (int i = 0; i < int'(KLEN); i++) s += longint'(kmem[i]) * longint'(acts[i]);
    return s;
  endfunction

  // kmode: 0 constant kval, 1 ramp kernel[i]=i, 2 random; amode 2 random else constant aval
  task automatic fill(input int kmode, input int kval, input int amode, input int aval);
    for (int i = 0; i < int'(KLEN); i++) begin
      case (kmode)
        0: kmem[i] = DATA_W'(kval);
        1: kmem[i] = DATA_W'(i);
        default: kmem[i] = DATA_W'($urandom);
      endcase
      acts[i] = (amode == 2) ? DATA_W'($urandom) : DATA_W'(aval);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Stream n beats. gap: 0 every cycle, 1 toggling, 2 random.
  task automatic stream(input int n, input int gap, output int edges, output bit ready_ok);
    int idx = 0;
    int tog = 0;
    edges = 0;
    ready_ok = 1'b1;
    while (idx < n && edges < 2000) begin
      if (edges != 0) @(negedge clk);
      if (!act_ready) ready_ok = 1'b0;
      case (gap)
        0: act_valid = 1'b1;
        1: act_valid = (tog == 0);
        default: act_valid = 1'($urandom_range(0, 1));
      endcase
      tog ^= 1;
      act_data = acts[idx];
      @(posedge clk);
      edges++;
      if (act_valid) idx++;
    end
    if (idx < n) chk("stream_timeout", idx, n);
  endtask

  // Full job: start, stream, optional backpressure with stray starts, handshake
  task automatic run_job(input string name, input int gap, input int bp, input longint exp);
    int edges;
    bit ready_ok, stable;
    int d0;
    logic [ACC_W-1:0] held;
    d0 = done_cnt;
    pulse_start();
    chk({name, "_busy"}, busy, 1);
    stream(int'(KLEN), gap, edges, ready_ok);
    @(negedge clk);
    act_valid = 1'b0;
    chk({name, "_ready_in_run"}, ready_ok, 1);
    chk({name, "_valid_lat1"}, res_valid, 1);
    chk({name, "_res"}, longint'($signed(res_data)), exp);
    if (gap == 0) chk({name, "_edges_to_last_beat"}, edges, KLEN);
    held = res_data;
    stable = 1'b1;
    for (int b = 0; b < bp; b++) begin
      start = (b % 3 == 0);
      @(negedge clk);
      if (!res_valid || res_data !== held || done || act_ready) stable = 1'b0;
    end
    start = 1'b0;
    if (bp > 0) begin
      chk({name, "_bp_stable"}, stable, 1);
      chk({name, "_bp_no_done"}, done_cnt - d0, 0);
    end
    res_ready = 1'b1;
    #1 chk({name, "_done_pulse"}, done, 1);
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, "_idle_after"}, busy, 0);
    chk({name, "_valid_low_after"}, res_valid, 0);
    chk({name, "_done_once"}, done_cnt - d0, 1);
  endtask

  typedef struct {
    string  name;
    int     kmode;
    int     kval;
    int     aval;
    int     gap;
    int     bp;
    longint exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int edges;
    bit rok;
    int d0;
    vecs[0] = '{"ones",        0,    1,    1, 0,  0,       64};
    vecs[1] = '{"neg_neg",     0, -128, -128, 0,  0,  1048576};
    vecs[2] = '{"neg_pos",     0, -128,  127, 0,  0, -1040384};
    vecs[3] = '{"ramp_nogap",  1,    0,    1, 0,  0,     2016};
    vecs[4] = '{"ramp_gaps",   1,    0,    1, 1,  0,     2016};
    vecs[5] = '{"backpress",   0,  127, -128, 0, 10, -1040384};
    vecs[6] = '{"zero_kernel", 0,    0,  100, 2,  3,        0};

    rst_n = 1'b0; start = 1'b0; kernel_valid = 1'b1; abort = 1'b0;
    act_valid = 1'b0; act_data = '0; res_ready = 1'b0;
    fill(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_act_ready", act_ready, 0);
    chk("rst_k_addr", k_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      fill(vecs[i].kmode, vecs[i].kval, 0, vecs[i].aval);
      run_job(vecs[i].name, vecs[i].gap, vecs[i].bp, vecs[i].exp);
    end

    // Start without a loaded kernel is ignored
    kernel_valid = 1'b0;
    pulse_start();
    chk("guard_idle", busy, 0);
    chk("guard_ready", act_ready, 0);
    kernel_valid = 1'b1;

    // Abort at beat 30: back to IDLE, no done
    fill(2, 0, 2, 0);
    d0 = done_cnt;
    pulse_start();
    stream(30, 0, edges, rok);
    @(negedge clk);
    abort = 1'b1; act_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; act_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", act_ready, 0);
    chk("abort_valid", res_valid, 0);
    chk("abort_k_addr", k_addr, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    run_job("after_abort", 0, 0, ref_dot());

    // Kernel valid dropping mid-run does not stop the job
    fill(2, 0, 2, 0);
    pulse_start();
    kernel_valid = 1'b0;
    run_job_tail_check();
    kernel_valid = 1'b1;

    // Async reset mid-run clears everything immediately
    fill(1, 0, 0, 1);
    pulse_start();
    stream(20, 0, edges, rok);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", act_ready, 0);
    chk("midrst_k_addr", k_addr, 0);
    chk("midrst_valid", res_valid, 0);
    chk("midrst_done", done, 0);
    act_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_after", busy, 0);

    // Randomized jobs against the reference model
    for (int r = 0; r < 6; r++) begin
      fill(2, 0, 2, 0);
      run_job("rand", 2, int'($urandom_range(0, 4)), ref_dot());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Finish the job started above with kernel_valid low
  task automatic run_job_tail_check();
    int edges;
    bit rok;
    stream(int'(KLEN), 0, edges, rok);
    @(negedge clk);
    act_valid = 1'b0;
    chk("kv_drop_valid", res_valid, 1);
    chk("kv_drop_res", longint'($signed(res_data)), ref_dot());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
